data_ram_pipe: RTL and testbench

DATA_RAM_PIPE -- requirements
Module: data_ram_pipe

---
 rtl/data_ram_pipe.sv | 164 ++++++++++++++++
 tb/tb_data_ram_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_pipe.sv
// Byte-addressed word RAM with power-on clear sequence and a fixed-latency response pipeline.
// Responses carry {valid, err, data} through RD_LAT register stages; there is no backpressure.
module data_ram_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W/8-1:0] req_sel,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(NB);
    localparam int unsigned IDX_HI = DEPTH_LOG2 + OFF_W;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   cnt_q, cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    req_ready_q, req_ready_d;

    logic                    pipe_valid_q [RD_LAT];
    logic                    pipe_valid_d [RD_LAT];
    logic                    pipe_err_q   [RD_LAT];
    logic                    pipe_err_d   [RD_LAT];
    logic [DATA_W-1:0]       pipe_data_q  [RD_LAT];
    logic [DATA_W-1:0]       pipe_data_d  [RD_LAT];

    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic                    accept_c;
    logic                    req_oor_c;
    logic [DEPTH_LOG2-1:0]   req_idx_c;
    logic                    mem_we_c;
    logic [DEPTH_LOG2-1:0]   mem_idx_c;
    logic [DATA_W-1:0]       mem_wdata_c;
    logic [NB-1:0]           mem_wmask_c;

    assign req_idx_c = req_addr[IDX_HI-1:OFF_W];

    // Any address bit above the word index makes the request out of range.
    generate
        if (ADDR_W > IDX_HI) begin : g_oor
            assign req_oor_c = |req_addr[ADDR_W-1:IDX_HI];
        end else begin : g_no_oor
            assign req_oor_c = 1'b0;
        end
        if (OFF_W > 0) begin : g_off
            logic unused_addr_off_c;
            assign unused_addr_off_c = ^req_addr[OFF_W-1:0];
        end
    endgenerate

    assign accept_c = req_valid && req_ready_q;

    // Control FSM: sweep-clear in INIT, then serve requests in RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        req_ready_d = req_ready_q;
        mem_we_c    = 1'b0;
        mem_idx_c   = cnt_q;
        mem_wdata_c = '0;
        mem_wmask_c = '0;
        case (state_q)
            ST_INIT: begin
                mem_we_c    = 1'b1;
                mem_wmask_c = '1;
                cnt_d       = cnt_q + DEPTH_LOG2'(1);
                if (cnt_q == '1) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                    req_ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept_c && req_we && !req_oor_c) begin
                    mem_we_c    = 1'b1;
                    mem_idx_c   = req_idx_c;
                    mem_wdata_c = req_wdata;
                    mem_wmask_c = req_sel;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Stage 0 captures the request outcome; later stages just shift.
    always_comb begin
        for (int i = 0; i < int'(RD_LAT); i++) begin
            pipe_valid_d[i] = 1'b0;
            pipe_err_d[i]   = 1'b0;
            pipe_data_d[i]  = '0;
        end
        pipe_valid_d[0] = accept_c;
        pipe_err_d[0]   = accept_c && req_oor_c;
        pipe_data_d[0]  = (accept_c && !req_we && !req_oor_c) ? mem_q[req_idx_c] : '0;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_err_d[i]   = pipe_err_q[i-1];
            pipe_data_d[i]  = pipe_data_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            req_ready_q <= 1'b0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_err_q[i]   <= 1'b0;
                pipe_data_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            req_ready_q <= req_ready_d;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_valid_q[i] <= pipe_valid_d[i];
                pipe_err_q[i]   <= pipe_err_d[i];
                pipe_data_q[i]  <= pipe_data_d[i];
            end
        end
    end

    // Storage array has no reset; contents are defined by the INIT sweep.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (mem_wmask_c[b]) begin
                    mem_q[mem_idx_c][b*8 +: 8] <= mem_wdata_c[b*8 +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign init_done = init_done_q;
    assign rsp_valid = pipe_valid_q[RD_LAT-1];
    assign rsp_err   = pipe_err_q[RD_LAT-1];
    assign rsp_rdata = pipe_data_q[RD_LAT-1];

endmodule

// File: tb/tb_data_ram_pipe.sv
// Randomized scoreboard bench for data_ram_pipe (DEPTH_LOG2=4, RD_LAT=3).
module tb_data_ram_pipe;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned RD_LAT     = 3;
    localparam int unsigned DEPTH      = 16;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_sel = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] mdl [DEPTH];
    exp_t        q [$];

    data_ram_pipe #(
        .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_sel(req_sel), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .init_done(init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.d);
                    chk("rsp_err", 32'(rsp_err), 32'(e.e));
                    chk("rsp_cycle", cyc, e.due);
                end
            end else begin
                chk("idle_rdata", rsp_rdata, 32'h0);
                chk("idle_err", 32'(rsp_err), 32'h0);
            end
            while (q.size() > 0 && q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL rsp_missing: got no response expected one at cycle %0d", q[0].due);
                void'(q.pop_front());
            end
        end
    end

    // Called at a falling edge; request is accepted on the following rising edge.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wd);
        exp_t        e;
        logic [3:0]  idx;
        bit          oor;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_sel   = sel;
        req_wdata = wd;
        chk("req_ready", 32'(req_ready), 32'h1);
        oor   = (addr >> 6) != 0;
        idx   = addr[5:2];
        e.d   = 32'h0;
        e.e   = oor;
        e.due = cyc + int'(RD_LAT);
        if (we) begin
            if (!oor)
                for (int b = 0; b < 4; b++)
                    if (sel[b]) mdl[idx][b*8 +: 8] = wd[b*8 +: 8];
        end else if (!oor) begin
            e.d = mdl[idx];
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Checks the clear sweep length starting right after reset release.
    task automatic check_init();
        for (int i = 1; i <= int'(DEPTH); i++) begin
            @(negedge clk);
            chk("init_ready", 32'(req_ready), (i == int'(DEPTH)) ? 32'h1 : 32'h0);
            chk("init_done", 32'(init_done), (i == int'(DEPTH)) ? 32'h1 : 32'h0);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < int'(DEPTH); a++) issue(1'b0, 32'(a * 4), 4'h0, 32'h0);
        idle(RD_LAT + 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_init_done", 32'(init_done), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        check_init();
        read_all();

        // Partial byte-lane write then read back.
        issue(1'b1, 32'h8, 4'b0101, 32'hAABBCCDD);
        issue(1'b0, 32'h8, 4'h0, 32'h0);
        // Read immediately following a write to the same word.
        issue(1'b1, 32'h4, 4'hF, 32'h12345678);
        issue(1'b0, 32'h4, 4'h0, 32'h0);
        // Out-of-range write must not alias onto word 0.
        issue(1'b1, 32'h40, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 32'h0, 4'h0, 32'h0);
        issue(1'b0, 32'h40, 4'h0, 32'h0);
        idle(2);
        // Four back-to-back reads.
        for (int i = 0; i < 4; i++) issue(1'b0, 32'(i * 4), 4'h0, 32'h0);
        idle(RD_LAT + 2);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] addr;
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h40;
            else addr = 32'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(RD_LAT + 2);
        chk("drain_empty", 32'(q.size()), 32'h0);

        // Reset with two responses still in the pipeline.
        issue(1'b0, 32'h8, 4'h0, 32'h0);
        issue(1'b0, 32'h4, 4'h0, 32'h0);
        req_valid = 1'b0;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'h0);
        chk("async_rst_ready", 32'(req_ready), 32'h0);
        chk("async_rst_done", 32'(init_done), 32'h0);
        q.delete();
        for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'h0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        check_init();
        read_all();
        chk("final_empty", 32'(q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
